uart_debug_tx: RTL

- Transmit-side framer for the UART debug link: converts one command/data word into a 7-byte packet on uart_tx.
- Packet byte order: 0xCD sync, cmd, data[7:0], data[15:8], data[23:16], data[31:24], CRC-8.
- Packet format matches the existing debug receiver, so a packet sent from this block decodes there with CRC residue 0.
- Drives debug responses and readback to the host, or host-side test fixtures.

---
 rtl/dbg_pkg.sv | 49 ++++
 rtl/uart_tx_byte.sv | 82 ++++++++
 rtl/uart_debug_tx.sv | 109 ++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_pkg
//  Description : Shared definitions for the UART debug link. Holds the sync
//                byte, packet length, command codes, the CRC-8 polynomial,
//                the transmit byte-state type and two small CRC helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package dbg_pkg;

  localparam logic [7:0] DBG_SYNC       = 8'hCD;
  localparam int         DBG_PKT_BYTES  = 7;

  localparam logic [7:0] DBG_CMD_WRITE  = 8'h00;
  localparam logic [7:0] DBG_CMD_ADDR   = 8'h01;
  localparam logic [7:0] DBG_CMD_CLRERR = 8'h02;

  // x^8 + x^2 + x + 1, non-reflected
  localparam logic [7:0] DBG_CRC_POLY   = 8'h07;

  // One state per byte of the packet.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_CMD  = 3'd2,
    ST_DAT0 = 3'd3,
    ST_DAT1 = 3'd4,
    ST_DAT2 = 3'd5,
    ST_DAT3 = 3'd6,
    ST_CRC  = 3'd7
  } dbg_byte_state_t;

  // One serial CRC-8 step, shift-left register, MSB is the feedback tap.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? DBG_CRC_POLY : 8'h00);
  endfunction

  // Check byte goes out register-MSB first while the serialiser sends LSB
  // first, so the register is bit-reversed before loading.
  function automatic logic [7:0] bit_reverse8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7 - i];
    return r;
  endfunction

endpackage : dbg_pkg
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : Serialises one byte as a 10-bit UART frame (start, 8 data
//                bits LSB first, stop). Exposes each data bit with a one-cycle
//                strobe for an external serial CRC.
//  Ports       : sys_clk, sys_rst  - clock, synchronous active-high reset
//                start, data        - load byte; first start-bit cycle follows
//                tx                 - serial output, idles high
//                crc_bit, crc_en    - current data bit and its one-cycle strobe
//                done               - high in the last cycle of the stop bit
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_byte
  import dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       crc_bit,
  output logic       crc_en,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;   // 0 start, 1..8 data, 9 stop
  logic [7:0]    shreg;
  logic          active;

  logic baud_end;
  assign baud_end = (baud_cnt == BAUD_LAST);

  // done is combinational so the next byte's start bit can follow the stop
  // bit with no idle cycle.
  assign done    = active && baud_end && (bit_idx == 4'd9);
  assign crc_en  = active && (baud_cnt == '0) && (bit_idx >= 4'd1) && (bit_idx <= 4'd8);
  assign crc_bit = tx;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx       <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shreg    <= 8'h00;
    end else if (start) begin
      tx       <= 1'b0;
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shreg    <= data;
    end else if (active) begin
      if (baud_end) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active  <= 1'b0;
          tx      <= 1'b1;
          bit_idx <= 4'd0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          if (bit_idx == 4'd8) begin
            tx <= 1'b1;
          end else begin
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule : uart_tx_byte
`default_nettype wire

// File: rtl/uart_debug_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_debug_tx
//  Description : Debug-link transmit framer. Sends one 7-byte packet
//                (0xCD, cmd, data LSB..MSB, CRC-8) per accepted request.
//  Ports       : sys_clk, sys_rst   - clock, synchronous active-high reset
//                tx_valid, tx_ready - request handshake
//                tx_cmd, tx_data    - command byte and payload word
//                uart_tx            - serial line, idles high
//                busy               - packet in flight (~tx_ready)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_debug_tx
  import dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_cmd,
  input  logic [31:0] tx_data,
  output logic        uart_tx,
  output logic        busy
);

  dbg_byte_state_t state;
  logic [7:0]      cmd_q;
  logic [31:0]     data_q;
  logic [7:0]      crc;

  logic       accept;
  logic       byte_start;
  logic [7:0] byte_data;
  logic       byte_done;
  logic       crc_bit;
  logic       crc_en;

  assign accept = tx_valid && tx_ready;
  assign busy   = ~tx_ready;

  // Next byte is loaded on the same edge the previous stop bit ends.
  always_comb begin
    byte_start = 1'b0;
    byte_data  = DBG_SYNC;
    case (state)
      ST_IDLE: begin byte_start = accept;    byte_data = DBG_SYNC;            end
      ST_SYNC: begin byte_start = byte_done; byte_data = cmd_q;               end
      ST_CMD:  begin byte_start = byte_done; byte_data = data_q[7:0];         end
      ST_DAT0: begin byte_start = byte_done; byte_data = data_q[15:8];        end
      ST_DAT1: begin byte_start = byte_done; byte_data = data_q[23:16];       end
      ST_DAT2: begin byte_start = byte_done; byte_data = data_q[31:24];       end
      ST_DAT3: begin byte_start = byte_done; byte_data = bit_reverse8(crc);   end
      default: begin byte_start = 1'b0;      byte_data = DBG_SYNC;            end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      tx_ready <= 1'b1;
      crc      <= 8'h00;
      cmd_q    <= 8'h00;
      data_q   <= 32'h0;
    end else begin
      // Check-byte bits are not folded back into the register.
      if (crc_en && (state != ST_CRC)) crc <= crc8_next(crc, crc_bit);
      case (state)
        ST_IDLE: if (accept) begin
          cmd_q    <= tx_cmd;
          data_q   <= tx_data;
          crc      <= 8'h00;
          tx_ready <= 1'b0;
          state    <= ST_SYNC;
        end
        ST_SYNC: if (byte_done) state <= ST_CMD;
        ST_CMD:  if (byte_done) state <= ST_DAT0;
        ST_DAT0: if (byte_done) state <= ST_DAT1;
        ST_DAT1: if (byte_done) state <= ST_DAT2;
        ST_DAT2: if (byte_done) state <= ST_DAT3;
        ST_DAT3: if (byte_done) state <= ST_CRC;
        ST_CRC:  if (byte_done) begin
          state    <= ST_IDLE;
          tx_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (byte_start),
    .data    (byte_data),
    .tx      (uart_tx),
    .crc_bit (crc_bit),
    .crc_en  (crc_en),
    .done    (byte_done)
  );

endmodule : uart_debug_tx
`default_nettype wire
